commit_trace_unit: RTL and testbench

- Sits directly downstream of the processor's commit point: the same retire signals the simulation bench samples (PC, instruction, register write, memory access, halt).
- Classifies each retired instruction, numbers it, and buffers it in a FIFO.
- Streams records out on a valid/ready port to a trace sink (hardware logger or bench).
- Signals when the halt record has drained.

---
 rtl/commit_trace_pkg.sv | 46 ++++
 rtl/trace_fifo.sv | 55 +++++
 rtl/commit_trace_unit.sv | 151 +++++++++++++++
 tb/tb_commit_trace_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace unit: record kinds, control states,
// the packed record layout and the retire classifier.
// Records are laid out LSB-first: kind, pc, inst, reg, regval, addr, memval,
// then the INUM_W-wide instruction number (and cycle stamp when enabled).
package commit_trace_pkg;

  localparam logic [2:0] KIND_REG   = 3'd0;
  localparam logic [2:0] KIND_LOAD  = 3'd1;
  localparam logic [2:0] KIND_STU   = 3'd2;
  localparam logic [2:0] KIND_STORE = 3'd3;
  localparam logic [2:0] KIND_NOP   = 3'd4;
  localparam logic [2:0] KIND_HALT  = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Fixed-width portion of a record; counter-width fields follow at INUM_OFF.
  localparam int KIND_OFF   = 0;
  localparam int PC_OFF     = 3;
  localparam int INST_OFF   = 19;
  localparam int REG_OFF    = 35;
  localparam int REGVAL_OFF = 38;
  localparam int ADDR_OFF   = 54;
  localparam int MEMVAL_OFF = 70;
  localparam int INUM_OFF   = 86;

  // Total record width for a given counter width, with or without cycle stamp.
  function automatic int rec_width(input int inum_w, input bit stamp);
    return INUM_OFF + (stamp ? 2 * inum_w : inum_w);
  endfunction

  // First match wins: register-writing forms take priority over halt/store.
  function automatic logic [2:0] classify(input logic rw, input logic mr,
                                          input logic mw, input logic h);
    if (rw && mw)      return KIND_STU;
    else if (rw && mr) return KIND_LOAD;
    else if (rw)       return KIND_REG;
    else if (h)        return KIND_HALT;
    else if (mw)       return KIND_STORE;
    else               return KIND_NOP;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO: head entry visible on rdata whenever not empty.
// Latency: a push into an empty FIFO is visible the following cycle.
// Backpressure: push is ignored when full unless a pop happens the same cycle;
// pop is ignored when empty.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Empty FIFO presents zeros so downstream fields idle at 0.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/commit_trace_unit.sv
// Classifies, numbers and buffers retired instructions into a trace stream.
// Latency: a retired record appears on tr_* one cycle after retire (no bypass).
// Backpressure: tr_valid/tr_ready; stall_req at <=1 free slot, refused retires set overflow.
// Ports: clk/rst (sync active-high); ret_* retire inputs; tr_* record stream;
// inst_count, stall_req, overflow, done status.
// Optional macro COMMIT_TRACE_CYCLE_STAMP_EN adds a cycle stamp per record (tr_cycle).
module commit_trace_unit
  import commit_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int INUM_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret_valid,
  input  logic [15:0]       ret_pc,
  input  logic [15:0]       ret_inst,
  input  logic              ret_regwrite,
  input  logic [2:0]        ret_wreg,
  input  logic [15:0]       ret_wdata,
  input  logic              ret_memread,
  input  logic              ret_memwrite,
  input  logic [15:0]       ret_memaddr,
  input  logic [15:0]       ret_memdata,
  input  logic              ret_halt,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [2:0]        tr_kind,
  output logic [INUM_W-1:0] tr_inum,
  output logic [15:0]       tr_pc,
  output logic [15:0]       tr_inst,
  output logic [2:0]        tr_reg,
  output logic [15:0]       tr_regval,
  output logic [15:0]       tr_addr,
  output logic [15:0]       tr_memval,
  output logic [INUM_W-1:0] inst_count,
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  output logic [INUM_W-1:0] tr_cycle,
`endif
  output logic              stall_req,
  output logic              overflow,
  output logic              done
);

  localparam int CW = $clog2(DEPTH+1);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  localparam int REC_W = rec_width(INUM_W, 1'b1);
`else
  localparam int REC_W = rec_width(INUM_W, 1'b0);
`endif

  state_e            state_q, state_d;
  logic [INUM_W-1:0] inst_count_q, inst_count_d;
  logic              overflow_q, overflow_d;
  logic [REC_W-1:0]  rec_in, rec_out;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop, in_run;
  logic [2:0]        kind;
  logic              has_reg, has_addr, has_mval;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [INUM_W-1:0] cycle_q;
  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + INUM_W'(1);
  end
`endif

  assign kind     = classify(ret_regwrite, ret_memread, ret_memwrite, ret_halt);
  assign has_reg  = (kind == KIND_REG)  || (kind == KIND_LOAD) || (kind == KIND_STU);
  assign has_addr = (kind == KIND_LOAD) || (kind == KIND_STU)  || (kind == KIND_STORE);
  assign has_mval = (kind == KIND_STU)  || (kind == KIND_STORE);

  assign in_run   = (state_q == ST_RUN);
  assign tr_valid = ~fifo_empty;
  assign pop      = tr_valid & tr_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = ret_valid & in_run & (~fifo_full | pop);

  always_comb begin
    rec_in = '0;
    rec_in[KIND_OFF   +: 3]      = kind;
    rec_in[PC_OFF     +: 16]     = ret_pc;
    rec_in[INST_OFF   +: 16]     = ret_inst;
    rec_in[REG_OFF    +: 3]      = has_reg  ? ret_wreg    : 3'd0;
    rec_in[REGVAL_OFF +: 16]     = has_reg  ? ret_wdata   : 16'd0;
    rec_in[ADDR_OFF   +: 16]     = has_addr ? ret_memaddr : 16'd0;
    rec_in[MEMVAL_OFF +: 16]     = has_mval ? ret_memdata : 16'd0;
    rec_in[INUM_OFF   +: INUM_W] = inst_count_q;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    rec_in[INUM_OFF + INUM_W +: INUM_W] = cycle_q;
`endif
  end

  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rec_in),
    .pop   (pop),
    .rdata (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    inst_count_d = inst_count_q;
    overflow_d   = overflow_q;
    if (push) inst_count_d = inst_count_q + INUM_W'(1);
    if (ret_valid && in_run && !push) overflow_d = 1'b1;
    case (state_q)
      ST_RUN:   if (push && kind == KIND_HALT) state_d = ST_DRAIN;
      // HALT is the last record pushed, so it is the last to pop.
      ST_DRAIN: if (pop && rec_out[KIND_OFF +: 3] == KIND_HALT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      inst_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_count_q <= inst_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign tr_kind    = rec_out[KIND_OFF   +: 3];
  assign tr_pc      = rec_out[PC_OFF     +: 16];
  assign tr_inst    = rec_out[INST_OFF   +: 16];
  assign tr_reg     = rec_out[REG_OFF    +: 3];
  assign tr_regval  = rec_out[REGVAL_OFF +: 16];
  assign tr_addr    = rec_out[ADDR_OFF   +: 16];
  assign tr_memval  = rec_out[MEMVAL_OFF +: 16];
  assign tr_inum    = rec_out[INUM_OFF   +: INUM_W];
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  assign tr_cycle   = rec_out[INUM_OFF + INUM_W +: INUM_W];
`endif
  assign inst_count = inst_count_q;
  assign stall_req  = (fifo_count >= CW'(DEPTH-1));
  assign overflow   = overflow_q;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench for commit_trace_unit: a queue-based reference model of the
// trace stream checked every cycle, plus hand-computed pins on key cycles.
module tb_commit_trace_unit;

  localparam int DEPTH  = 8;
  localparam int INUM_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ret_valid, ret_regwrite, ret_memread, ret_memwrite, ret_halt;
  logic [15:0] ret_pc, ret_inst, ret_wdata, ret_memaddr, ret_memdata;
  logic [2:0]  ret_wreg;
  logic        tr_valid, tr_ready, stall_req, overflow, done;
  logic [2:0]  tr_kind, tr_reg;
  logic [INUM_W-1:0] tr_inum, inst_count;
  logic [15:0] tr_pc, tr_inst, tr_regval, tr_addr, tr_memval;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [INUM_W-1:0] tr_cycle;
`endif

  commit_trace_unit #(.DEPTH(DEPTH), .INUM_W(INUM_W)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_regwrite(ret_regwrite), .ret_wreg(ret_wreg), .ret_wdata(ret_wdata),
    .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_memaddr(ret_memaddr),
    .ret_memdata(ret_memdata), .ret_halt(ret_halt), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_kind(tr_kind), .tr_inum(tr_inum), .tr_pc(tr_pc), .tr_inst(tr_inst), .tr_reg(tr_reg),
    .tr_regval(tr_regval), .tr_addr(tr_addr), .tr_memval(tr_memval), .inst_count(inst_count),
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    .tr_cycle(tr_cycle),
`endif
    .stall_req(stall_req), .overflow(overflow), .done(done)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          kind;
    logic [31:0] inum, cyc;
    logic [15:0] pc, inst, rv, ad, mv;
    logic [2:0]  rg;
  } rec_t;

  rec_t        q[$];
  logic [31:0] icnt, cyc_m;
  bit          ovf, halted, done_m, live;
  bit          pop_m, push_m;
  rec_t        r, rp;

  // Kind from the retire flags, first match wins.
  function automatic int kind_of(logic rw, logic mr, logic mw, logic h);
    if (rw && mw) return 2;
    if (rw && mr) return 1;
    if (rw)       return 0;
    if (h)        return 5;
    if (mw)       return 3;
    return 4;
  endfunction

  initial begin
    live = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete(); icnt = 0; cyc_m = 0; ovf = 0; halted = 0; done_m = 0; live = 1;
      end else begin
        pop_m  = (q.size() != 0) && tr_ready;
        push_m = ret_valid && !halted && (q.size() < DEPTH || pop_m);
        if (ret_valid && !halted && !push_m) ovf = 1;
        if (pop_m) begin
          rp = q.pop_front();
          if (rp.kind == 5) done_m = 1;
        end
        if (push_m) begin
          r.kind = kind_of(ret_regwrite, ret_memread, ret_memwrite, ret_halt);
          r.pc   = ret_pc;
          r.inst = ret_inst;
          r.rg   = (r.kind <= 2) ? ret_wreg : 3'd0;
          r.rv   = (r.kind <= 2) ? ret_wdata : 16'd0;
          r.ad   = (r.kind >= 1 && r.kind <= 3) ? ret_memaddr : 16'd0;
          r.mv   = (r.kind == 2 || r.kind == 3) ? ret_memdata : 16'd0;
          r.inum = icnt;
          r.cyc  = cyc_m;
          q.push_back(r);
          icnt = icnt + 1;
          if (r.kind == 5) halted = 1;
        end
        cyc_m = cyc_m + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  localparam int P_VALID = 0, P_KIND = 1, P_INUM = 2, P_PC = 3, P_REG = 4, P_REGVAL = 5,
                 P_ADDR = 6, P_MEMVAL = 7, P_ICNT = 8, P_STALL = 9, P_OVF = 10,
                 P_DONE = 11, P_CYCLE = 12;

  typedef struct { string nm; int sel; logic [31:0] exp; } pin_t;
  pin_t pins[$];
  pin_t pp;
  int   vectors = 0, miscompares = 0;

  function automatic logic [31:0] act_of(int sel);
    case (sel)
      P_VALID:  return 32'(tr_valid);
      P_KIND:   return 32'(tr_kind);
      P_INUM:   return 32'(tr_inum);
      P_PC:     return 32'(tr_pc);
      P_REG:    return 32'(tr_reg);
      P_REGVAL: return 32'(tr_regval);
      P_ADDR:   return 32'(tr_addr);
      P_MEMVAL: return 32'(tr_memval);
      P_ICNT:   return 32'(inst_count);
      P_STALL:  return 32'(stall_req);
      P_OVF:    return 32'(overflow);
      P_DONE:   return 32'(done);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
      P_CYCLE:  return 32'(tr_cycle);
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("tr_valid", 32'(tr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("tr_kind",   32'(tr_kind),   32'(q[0].kind));
        chk("tr_inum",   32'(tr_inum),   q[0].inum);
        chk("tr_pc",     32'(tr_pc),     32'(q[0].pc));
        chk("tr_inst",   32'(tr_inst),   32'(q[0].inst));
        chk("tr_reg",    32'(tr_reg),    32'(q[0].rg));
        chk("tr_regval", 32'(tr_regval), 32'(q[0].rv));
        chk("tr_addr",   32'(tr_addr),   32'(q[0].ad));
        chk("tr_memval", 32'(tr_memval), 32'(q[0].mv));
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
        chk("tr_cycle",  32'(tr_cycle),  q[0].cyc);
`endif
      end
      chk("inst_count", 32'(inst_count), icnt);
      chk("stall_req",  32'(stall_req),  32'(q.size() >= DEPTH - 1));
      chk("overflow",   32'(overflow),   32'(ovf));
      chk("done",       32'(done),       32'(done_m));
    end
    while (pins.size() != 0) begin
      pp = pins.pop_front();
      chk(pp.nm, act_of(pp.sel), pp.exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int sel, input logic [31:0] exp);
    pin_t p;
    p.nm = nm; p.sel = sel; p.exp = exp;
    pins.push_back(p);
  endtask

  task automatic retire(input logic rw, input logic mr, input logic mw, input logic h,
                        input logic [15:0] pc, input logic [15:0] inst, input logic [2:0] wr,
                        input logic [15:0] wd, input logic [15:0] ad, input logic [15:0] md);
    ret_valid = 1; ret_regwrite = rw; ret_memread = mr; ret_memwrite = mw; ret_halt = h;
    ret_pc = pc; ret_inst = inst; ret_wreg = wr; ret_wdata = wd;
    ret_memaddr = ad; ret_memdata = md;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) begin
      retire(i % 3 == 2, 1'b0, i % 3 == 0, 1'b0, 16'(16'h0100 + 2 * i), 16'(16'h1000 + i),
             3'(i), 16'(16'hA000 + i), 16'(16'h0200 + i), 16'(16'hC000 + i));
      step();
      if (i == 5) pin("stall_after_6", P_STALL, 0);
      if (i == 6) pin("stall_after_7", P_STALL, 1);
    end
  endtask

  initial begin
    rst = 1; tr_ready = 0;
    retire(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ret_valid = 0;
    step(); step();
    pin("rst_valid", P_VALID, 0); pin("rst_icnt", P_ICNT, 0);
    pin("rst_ovf", P_OVF, 0);     pin("rst_done", P_DONE, 0);
    pin("rst_kind", P_KIND, 0);

    // Basic kinds with ready high.
    rst = 0; tr_ready = 1;
    retire(1, 0, 0, 0, 16'h0000, 16'h3A5C, 3'd3, 16'h1234, 16'h5555, 16'h6666); step();
    pin("reg_valid", P_VALID, 1); pin("reg_kind", P_KIND, 0); pin("reg_inum", P_INUM, 0);
    pin("reg_reg", P_REG, 3); pin("reg_val", P_REGVAL, 32'h1234);
    pin("reg_addr", P_ADDR, 0); pin("reg_icnt", P_ICNT, 1);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    pin("reg_cycle", P_CYCLE, 0);
`endif
    retire(1, 0, 1, 0, 16'h0002, 16'h7A11, 3'd2, 16'h0A0A, 16'h0040, 16'hBEEF); step();
    pin("stu_kind", P_KIND, 2); pin("stu_inum", P_INUM, 1); pin("stu_reg", P_REG, 2);
    pin("stu_val", P_REGVAL, 32'h0A0A); pin("stu_addr", P_ADDR, 32'h40);
    pin("stu_mval", P_MEMVAL, 32'hBEEF);
    retire(1, 1, 0, 0, 16'h0004, 16'h5B22, 3'd5, 16'h00FF, 16'h0010, 16'h7777); step();
    pin("ld_kind", P_KIND, 1); pin("ld_addr", P_ADDR, 32'h10); pin("ld_mval", P_MEMVAL, 0);
    ret_valid = 0; step();
    pin("idle_valid", P_VALID, 0); pin("idle_icnt", P_ICNT, 3);

    // Phase A: fill with ready low, 9th retire dropped, then drain in order.
    rst = 1; step(); rst = 0; tr_ready = 0;
    fill8();
    retire(0, 0, 0, 0, 16'h0200, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0); step();
    pin("drop_ovf", P_OVF, 1); pin("drop_icnt", P_ICNT, 8); pin("drop_head", P_INUM, 0);
    ret_valid = 0; step();
    pin("hold_inum", P_INUM, 0); pin("hold_kind", P_KIND, 3); pin("hold_pc", P_PC, 32'h0100);
    tr_ready = 1;
    repeat (8) step();
    pin("drainA_valid", P_VALID, 0);

    // Phase B: full FIFO accepts a retire when the head pops that cycle.
    rst = 1; step(); rst = 0; tr_ready = 0;
    fill8();
    tr_ready = 1;
    retire(1, 0, 0, 0, 16'h0300, 16'h2222, 3'd1, 16'h0101, 16'h0, 16'h0); step();
    pin("full_icnt", P_ICNT, 9); pin("full_ovf", P_OVF, 0);
    pin("full_stall", P_STALL, 1); pin("full_head", P_INUM, 1);
    ret_valid = 0;
    repeat (8) step();
    pin("drainB_valid", P_VALID, 0);

    // Halt: retires after HALT are ignored; done follows the HALT pop.
    tr_ready = 0;
    for (int i = 0; i < 7; i++) begin
      retire(1, 0, 0, 0, 16'(16'h0010 + 2 * i), 16'h4000, 3'd4, 16'(i), 16'h0, 16'h0);
      step();
    end
    retire(0, 0, 1, 1, 16'h0022, 16'hF000, 3'd0, 16'h0, 16'h0099, 16'h0088); step();
    pin("halt_icnt", P_ICNT, 17); pin("halt_stall", P_STALL, 1);
    retire(1, 0, 0, 0, 16'h0024, 16'h4000, 3'd1, 16'h0, 16'h0, 16'h0);
    repeat (3) step();
    pin("drain_ovf", P_OVF, 0); pin("drain_icnt", P_ICNT, 17);
    tr_ready = 1;
    repeat (7) step();
    pin("halt_kind", P_KIND, 5); pin("halt_pc", P_PC, 32'h22); pin("halt_addr", P_ADDR, 0);
    pin("halt_inum", P_INUM, 16); pin("halt_notdone", P_DONE, 0);
    step();
    pin("done_set", P_DONE, 1); pin("done_valid", P_VALID, 0);
    ret_valid = 0;
    step(); step();
    pin("done_hold", P_DONE, 1); pin("done_icnt", P_ICNT, 17);

    // Mid-operation reset with records buffered.
    rst = 1; step(); rst = 0; tr_ready = 0;
    pin("rst2_done", P_DONE, 0);
    for (int i = 0; i < 3; i++) begin
      retire(0, 0, 0, 0, 16'(16'h0400 + i), 16'h0, 3'd0, 16'h0, 16'h0, 16'h0);
      step();
    end
    pin("buf3_valid", P_VALID, 1); pin("buf3_icnt", P_ICNT, 3);
    ret_valid = 0; rst = 1; step();
    pin("rst3_valid", P_VALID, 0); pin("rst3_icnt", P_ICNT, 0);
    pin("rst3_ovf", P_OVF, 0);     pin("rst3_done", P_DONE, 0);
    rst = 0; tr_ready = 0;
    retire(1, 0, 0, 0, 16'h0500, 16'h1111, 3'd7, 16'h7777, 16'h0, 16'h0); step();
    pin("post_inum", P_INUM, 0); pin("post_icnt", P_ICNT, 1);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    pin("post_cycle0", P_CYCLE, 0);
`endif
    ret_valid = 0; tr_ready = 1; step(); step();
    retire(0, 0, 0, 0, 16'h0502, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0); step();
    pin("post2_inum", P_INUM, 1); pin("post2_kind", P_KIND, 4);
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    pin("post_cycle3", P_CYCLE, 3);
`endif
    ret_valid = 0; step(); step();

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
